// File: rtl/rgbi_capture_if.sv
// Frame-buffer write channel of rgbi_capture: valid/ready handshake carrying a packed
// pixel word and its {page, line, word} address.
interface rgbi_capture_if #(
    parameter int DW = 16,
    parameter int AW = 15
);
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_adr;

    modport master (output wr_valid, output wr_data, output wr_adr, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_adr, output wr_ready);
endinterface

// File: rtl/rgbi_capture.sv
// RGBI capture: sync-locked pixel divider, line/pixel counters, vsync detect and word packing.
// Optional CAP_PHASE_EN adds phase_i to select the sampling point within each pixel period.
module rgbi_capture #(
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 4,
    parameter int DIV          = 5,
    parameter int H_START      = 52,
    parameter int H_WORDS      = 64,
    parameter int V_START      = 0,
    parameter int V_LINES      = 240,
    parameter int VS_DET       = 254
) (
    input  logic                    clk_dot,
    input  logic                    reset,
    input  logic                    csync_i,
    input  logic [PIX_W-1:0]        pix_in_i,
`ifdef CAP_PHASE_EN
    input  logic [$clog2(DIV)-1:0]  phase_i,
`endif
    rgbi_capture_if.master          wr,
    output logic                    page_o,
    output logic                    frame_done_o,
    output logic                    overflow_o
);
    localparam int DW    = PIX_W * PIX_PER_WORD;
    localparam int LW    = $clog2(V_LINES);
    localparam int WW    = $clog2(H_WORDS);
    localparam int AW    = 1 + LW + WW;
    localparam int SW    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int DCW   = $clog2(DIV);
    localparam int H_END = H_START + H_WORDS * PIX_PER_WORD;
    localparam int V_END = V_START + V_LINES;

    logic           cs_m_q, cs_s_q, cs_prev_q;
    logic [DCW-1:0] div_cnt_q, div_cnt_d, stb_pos;
    logic [8:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, h_rel;
    logic           vs_seen_q, vs_seen_d, line_det_q, line_det_d;
    logic           page_q, page_d, fd_q, fd_d, ovf_q, ovf_d;
    logic [DW-1:0]  pack_q, pack_d, word_nxt, wr_data_q, wr_data_d;
    logic [AW-1:0]  wr_adr_q, wr_adr_d;
    logic           wr_valid_q, wr_valid_d;
    logic           fe, strobe, vs_det, vs_new, line_act, h_act, capture, word_done, xfer;
    logic [SW-1:0]  slot;

`ifdef CAP_PHASE_EN
    assign stb_pos = (int'(phase_i) >= DIV) ? DCW'(DIV - 1) : phase_i;
`else
    assign stb_pos = DCW'(DIV - 1);
`endif

    always_comb begin
        fe        = cs_prev_q & ~cs_s_q;
        strobe    = (div_cnt_q == stb_pos) & ~fe;
        vs_det    = strobe & (h_cnt_q == 9'(VS_DET)) & ~cs_s_q;
        vs_new    = vs_det & ~vs_seen_q;
        h_rel     = h_cnt_q - 9'(H_START);
        slot      = SW'(h_rel % 9'(PIX_PER_WORD));
        line_act  = (int'(v_cnt_q) >= V_START) && (int'(v_cnt_q) < V_END);
        h_act     = (int'(h_cnt_q) >= H_START) && (int'(h_cnt_q) < H_END);
        capture   = strobe & line_act & h_act;
        word_done = capture & (slot == SW'(PIX_PER_WORD - 1));
        xfer      = wr_valid_q & wr.wr_ready;
        word_nxt  = pack_q;
        word_nxt[slot*PIX_W +: PIX_W] = pix_in_i;
    end

    always_comb begin
        div_cnt_d  = (fe || div_cnt_q == DCW'(DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        vs_seen_d  = vs_seen_q;
        line_det_d = line_det_q;
        page_d     = page_q;
        fd_d       = vs_new;
        pack_d     = capture ? word_nxt : pack_q;
        ovf_d      = ovf_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        wr_adr_d   = wr_adr_q;

        if (fe) begin
            h_cnt_d    = '0;
            line_det_d = 1'b0;
            if (v_cnt_q != 9'd511) v_cnt_d = v_cnt_q + 1'b1;
            // a line without detection ends the vsync interval
            if (!line_det_q) vs_seen_d = 1'b0;
        end else if (strobe && h_cnt_q != 9'd511) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        if (vs_det) line_det_d = 1'b1;
        if (vs_new) begin
            page_d    = ~page_q;
            vs_seen_d = 1'b1;
            v_cnt_d   = '0;
        end

        if (xfer) wr_valid_d = 1'b0;
        if (word_done) begin
            if (!wr_valid_q || wr.wr_ready) begin
                wr_valid_d = 1'b1;
                wr_data_d  = word_nxt;
                wr_adr_d   = {page_q, LW'(v_cnt_q - 9'(V_START)), WW'(h_rel / 9'(PIX_PER_WORD))};
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            cs_m_q     <= 1'b1;
            cs_s_q     <= 1'b1;
            cs_prev_q  <= 1'b1;
            div_cnt_q  <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            vs_seen_q  <= 1'b0;
            line_det_q <= 1'b0;
            page_q     <= 1'b0;
            fd_q       <= 1'b0;
            ovf_q      <= 1'b0;
            pack_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_adr_q   <= '0;
        end else begin
            cs_m_q     <= csync_i;
            cs_s_q     <= cs_m_q;
            cs_prev_q  <= cs_s_q;
            div_cnt_q  <= div_cnt_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            vs_seen_q  <= vs_seen_d;
            line_det_q <= line_det_d;
            page_q     <= page_d;
            fd_q       <= fd_d;
            ovf_q      <= ovf_d;
            pack_q     <= pack_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_adr_q   <= wr_adr_d;
        end
    end

    assign wr.wr_valid    = wr_valid_q;
    assign wr.wr_data     = wr_data_q;
    assign wr.wr_adr      = wr_adr_q;
    assign page_o         = page_q;
    assign frame_done_o   = fd_q;
    assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_rgbi_capture.sv
// Scoreboard bench for rgbi_capture: line-level reference model predicts every written word.
module tb_rgbi_capture;
    localparam int PIX_W = 4, PPW = 4, DIV = 5, H_START = 52, H_WORDS = 64;
    localparam int V_START = 0, V_LINES = 240, VS_DET = 254;
    localparam int DW = PIX_W * PPW, LW = 8, WW = 6, AW = 1 + LW + WW;
`ifdef CAP_PHASE_EN
    localparam int PH = 2;
`else
    localparam int PH = DIV - 1;
`endif
    // strobe edge of pixel k (edges counted from the first clock after csync falls)
    localparam int S0   = 3 + PH;
    localparam int BASE = S0 - DIV + 1;
    localparam int C0   = S0 + DIV * (H_START + PPW - 1);

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] adr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic csync;
    logic [PIX_W-1:0] pix;
    logic page, fd, ovf;
    always #5 clk = ~clk;

    rgbi_capture_if #(.DW(DW), .AW(AW)) wr_if();

    rgbi_capture dut (
        .clk_dot      (clk),
        .reset        (rst),
        .csync_i      (csync),
        .pix_in_i     (pix),
`ifdef CAP_PHASE_EN
        .phase_i      (3'd2),
`endif
        .wr           (wr_if),
        .page_o       (page),
        .frame_done_o (fd),
        .overflow_o   (ovf)
    );

    exp_t sb_q[$];
    exp_t got;
    int n_tests = 0, n_fail = 0, n_fd = 0;
    logic [PIX_W-1:0] lpix [512];
    int m_v = 0, m_page = 0, m_vs_seen = 0, m_prev_det = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: sample one step after the falling edge, i.e. what the next rising edge will see
    logic held_prev = 1'b0;
    logic [DW-1:0] held_d;
    logic [AW-1:0] held_a;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            held_prev = 1'b0;
        end else begin
            if (fd) n_fd++;
            if (held_prev) begin
                check("hold_valid", 32'(wr_if.wr_valid), 32'd1);
                check("hold_data", 32'(wr_if.wr_data), 32'(held_d));
                check("hold_adr", 32'(wr_if.wr_adr), 32'(held_a));
            end
            if (wr_if.wr_valid && wr_if.wr_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", 32'(wr_if.wr_adr), 32'hFFFF_FFFF);
                end else begin
                    got = sb_q.pop_front();
                    check("word_data", 32'(wr_if.wr_data), 32'(got.data));
                    check("word_adr", 32'(wr_if.wr_adr), 32'(got.adr));
                end
            end
            held_prev = wr_if.wr_valid && !wr_if.wr_ready;
            held_d    = wr_if.wr_data;
            held_a    = wr_if.wr_adr;
        end
    end

    // mode: 0 random ready, 1 always ready, 2 ready returns as word 1 completes,
    //       3 ready low across word 1 (dropped), 4 ready low then reset while holding
    task automatic run_line(input int lc, input int low_e, input int mode,
                            input bit det_line, input bit fixed_data);
        int old_v, old_p, new_p, v_c, p_c, last_h, k;
        bit first_det;
        exp_t e;
        for (int h = 0; h < 512; h++)
            lpix[h] = fixed_data ? ((h >= H_START) ? PIX_W'((h - H_START) % PPW + 1) : '0)
                                 : PIX_W'($urandom);
        if (!m_prev_det) m_vs_seen = 0;
        if (m_v < 511) m_v++;
        m_prev_det = det_line;
        first_det  = det_line && !m_vs_seen;
        old_v = m_v;
        old_p = m_page;
        new_p = first_det ? 1 - m_page : m_page;
        for (int w = 0; w < H_WORDS; w++) begin
            last_h = H_START + PPW * w + PPW - 1;
            v_c = (first_det && last_h > VS_DET) ? 0 : old_v;
            p_c = (first_det && last_h > VS_DET) ? new_p : old_p;
            if (S0 + DIV * last_h <= lc + 1 && v_c >= V_START && v_c < V_START + V_LINES
                && !(mode == 3 && w == 1) && mode != 4) begin
                for (int s = 0; s < PPW; s++)
                    e.data[s*PIX_W +: PIX_W] = lpix[H_START + PPW * w + s];
                e.adr = {1'(p_c), LW'(v_c - V_START), WW'(w)};
                sb_q.push_back(e);
            end
        end
        if (first_det) begin
            m_v = 0;
            m_page = new_p;
            m_vs_seen = 1;
        end

        for (int ed = 0; ed < lc; ed++) begin
            @(negedge clk);
            if (mode == 2 && ed == C0 + DIV * PPW + 1) begin
                check("samecycle_valid", 32'(wr_if.wr_valid), 32'd1);
                check("samecycle_word", 32'(wr_if.wr_adr[WW-1:0]), 32'd1);
            end
            if (mode == 3 && ed == C0 + DIV * PPW + 1) begin
                check("drop_ovf", 32'(ovf), 32'd1);
                check("drop_held_word", 32'(wr_if.wr_adr[WW-1:0]), 32'd0);
            end
            if (mode == 4 && ed == C0 + 3) begin
                check("pre_reset_valid", 32'(wr_if.wr_valid), 32'd1);
                #2 rst = 1'b1;
                #1;
                check("rst_async_valid", 32'(wr_if.wr_valid), 32'd0);
                check("rst_async_data", 32'(wr_if.wr_data), 32'd0);
                check("rst_async_adr", 32'(wr_if.wr_adr), 32'd0);
                check("rst_async_page", 32'(page), 32'd0);
                check("rst_async_ovf", 32'(ovf), 32'd0);
                return;
            end
            csync = (ed < low_e) ? 1'b0 : 1'b1;
            k = (ed >= BASE) ? (ed - BASE) / DIV : 0;
            pix = (ed >= BASE && k < 512) ? lpix[k] : '0;
            case (mode)
                0: wr_if.wr_ready = ($urandom_range(0, 3) != 0);
                2: wr_if.wr_ready = !(ed > C0 && ed < C0 + DIV * PPW);
                3: wr_if.wr_ready = !(ed > C0 && ed < C0 + DIV * PPW + 8);
                4: wr_if.wr_ready = 1'b0;
                default: wr_if.wr_ready = 1'b1;
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        csync = 1'b1;
        pix = '0;
        wr_if.wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(wr_if.wr_valid), 32'd0);
        check("reset_data", 32'(wr_if.wr_data), 32'd0);
        check("reset_adr", 32'(wr_if.wr_adr), 32'd0);
        check("reset_page", 32'(page), 32'd0);
        check("reset_fd", 32'(fd), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 4; i++) run_line(1600 + $urandom_range(0, 30), 20, 0, 0, 0);
        run_line(1600, 20, 1, 0, 1);                 // v_cnt=5, stepping pixels -> 16'h4321
        run_line(1600, 20, 2, 0, 0);
        check("samecycle_no_ovf", 32'(ovf), 32'd0);
        run_line(S0 + DIV * 53, 20, 1, 0, 0);        // next sync edge lands at h_cnt=54
        for (int i = 0; i < 3; i++) run_line(1600, S0 + DIV * 270, 0, 1, 0);
        check("vsync_frame_done_count", 32'(n_fd), 32'd1);
        check("vsync_page", 32'(page), 32'd1);
        for (int i = 0; i < 2; i++) run_line(1600 + $urandom_range(0, 30), 20, 0, 0, 0);
        run_line(1600, 20, 3, 0, 0);
        run_line(1600, 20, 0, 0, 0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("frame_done_total", 32'(n_fd), 32'd1);
        run_line(1600, 20, 4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rgbi_capture.md
Name: rgbi_capture

Overview:
Parametrised successor to the RGBI input sampler. It recovers the pixel clock from the fast capture clock with a sync-locked divider, counts lines and pixels from composite sync, and detects vertical sync as sync held low past a programmable pixel count. Pixels inside a programmable active window are packed into RAM words and handed to the frame-buffer writer over a valid/ready handshake with {page, line, word} addresses. It sits between the RGBI pins and the SPRAM write arbiter.

Parameters:
PIX_W, 4, bits per pixel (RGBI = 4).
PIX_PER_WORD, 4, pixels packed per RAM word; word width = PIX_W*PIX_PER_WORD.
DIV, 5, capture clocks per pixel, minimum 2.
H_START, 52, first active pixel, counted from the sync falling edge.
H_WORDS, 64, active words per line.
V_START, 0, first active line after vsync detection.
V_LINES, 240, active lines per frame.
VS_DET, 254, pixel count at which sync still low means vertical sync.

Ports:
clk_dot  in  1  capture clock (35 MHz class).
reset  in  1  asynchronous, active-high reset.
csync  in  1  composite sync, active low, asynchronous to clk_dot.
pix_in  in  PIX_W  pixel bus, sampled on the strobe.
wr_valid  out  1  a word is available.
wr_ready  in  1  writer accepts the word.
wr_data  out  PIX_W*PIX_PER_WORD  packed word; first pixel in bits [PIX_W-1:0].
wr_adr  out  1+clog2(V_LINES)+clog2(H_WORDS)  address {page, line, word}.
page  out  1  buffer currently being written.
frame_done  out  1  one-cycle pulse on each new vertical sync.
overflow  out  1  sticky flag: a word was dropped.

Behaviour:
- Reset values: wr_valid=0, wr_data=0, wr_adr=0, page=0, frame_done=0, overflow=0. All internal counters are 0 and the synchroniser flops are 1.
- csync passes through a 2-flop synchroniser (cs_s). A falling edge (fe) is prev=1 and cs_s=0.
- Divider div_cnt counts 0..DIV-1 and wraps. On fe it is forced to 0. The sample strobe is div_cnt==DIV-1 and fe is low.
- h_cnt is 9 bits. It is set to 0 on fe, increments on each strobe, and saturates at 511.
- Vertical sync detection: strobe and h_cnt==VS_DET and cs_s==0.
  - If vs_seen is clear: toggle page, pulse frame_done, set vs_seen, set v_cnt=0.
  - vs_seen clears on the first fe where the previous line had no detection. A multi-line vsync therefore toggles page only once.
- v_cnt is 9 bits. It increments on fe and saturates at 511. A line is active when V_START <= v_cnt < V_START+V_LINES. Stored line = v_cnt-V_START.
- Window:
  - A pixel is captured on a strobe when its line is active and H_START <= h_cnt < H_START+H_WORDS*PIX_PER_WORD.
  - Slot index = (h_cnt-H_START) mod PIX_PER_WORD. Word index = (h_cnt-H_START)/PIX_PER_WORD.
- Word completion happens when the last slot is captured.
  - In the next cycle, wr_data, wr_adr and wr_valid=1 are loaded. Latency is 1 clk_dot from the final strobe.
  - The page bit in wr_adr is the page value at completion.
- Handshake:
  - A transfer happens when wr_valid and wr_ready are both high; wr_valid then drops the next cycle unless a new word loads.
  - New word and transfer in the same cycle: the new word loads and wr_valid stays 1.
  - New word while wr_valid=1 and wr_ready=0: the new word is dropped, the held word is unchanged, and overflow is set. overflow clears only on reset.
- A fe in the middle of a word discards the partial word; no write is made.
- Reset asserted at any time returns all state immediately to the reset values. A held word is lost.

Optional Feature:
CAP_PHASE_EN:
- When defined, the block adds an input port phase [clog2(DIV)-1:0]. The strobe becomes div_cnt==phase, with phase >= DIV clamped to DIV-1. This lets the sampling point be centred on the pixel eye.
- When undefined, the port is absent and the strobe is fixed at div_cnt==DIV-1.

Test Plan:
- Defaults, wr_ready=1, one line with v_cnt=5, pix_in stepping 1,2,3,4 per pixel from h_cnt=52 -> first word wr_data=16'h4321, wr_adr={0,8'd5,6'd0}; 64 words per line, each 1 clk after its 4th strobe.
- csync held low past pixel 254 for 3 consecutive lines -> exactly one frame_done pulse, page 0->1, v_cnt restarts at 0.
- wr_ready=0 for 2 word periods -> first word held stable, second word dropped, overflow=1; raising wr_ready transfers the first word.
- wr_ready rises in the same cycle the next word completes -> no drop, overflow stays 0, wr_valid continuous.
- Sync falling edge at h_cnt=54 (mid-word) -> no write for that partial word, div_cnt=0 next cycle.
- Reset asserted while wr_valid=1 -> wr_valid=0 immediately; with CAP_PHASE_EN and phase=2, DIV=5, samples occur at div_cnt==2.
